// File: rtl/memory_stage_if.sv
// Bundle types and the pipeline/data-bus interface for the MEM stage.

package memory_stage_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned RD_W   = 5;

  // EX/MEM bundle presented by the execute stage
  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] reg2_value;
    logic [RD_W-1:0]   reg_dest_addr;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic [2:0]        funct3;
  } ex_mem_t;

  // MEM/WB bundle handed to writeback
  typedef struct packed {
    logic [RD_W-1:0]   reg_dest_addr;
    logic              reg_write;
    logic [DATA_W-1:0] wb_value;
  } mem_wb_t;

endpackage

interface memory_stage_if;
  import memory_stage_pkg::*;

  logic              ex_mem_valid;
  ex_mem_t           ex_mem_state;
  logic              stall;
  logic              dreq_valid;
  logic [DATA_W-1:0] dreq_addr;
  logic              dreq_write;
  logic [7:0]        dreq_strobe;
  logic [DATA_W-1:0] dreq_wdata;
  logic              dresp_valid;
  logic [DATA_W-1:0] dresp_rdata;
  logic              mem_wb_valid;
  mem_wb_t           mem_wb_state;
  logic              misalign_err;

  // Environment side: upstream pipeline, data memory and writeback
  modport master (
    output ex_mem_valid, ex_mem_state, dresp_valid, dresp_rdata,
    input  stall, dreq_valid, dreq_addr, dreq_write, dreq_strobe, dreq_wdata,
    input  mem_wb_valid, mem_wb_state, misalign_err
  );

  // MEM stage side
  modport slave (
    input  ex_mem_valid, ex_mem_state, dresp_valid, dresp_rdata,
    output stall, dreq_valid, dreq_addr, dreq_write, dreq_strobe, dreq_wdata,
    output mem_wb_valid, mem_wb_state, misalign_err
  );

endinterface

// File: rtl/memory_stage.sv
// RV64 MEM stage: issues loads/stores on the data bus, aligns and extends
// read data, and registers the MEM/WB bundle. Stalls upstream while busy.

module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic           clock,
  input  logic           reset_n,
  memory_stage_if.slave  bus
);

  localparam int unsigned LANE_W = 3;
  localparam int unsigned STRB_W = XLEN / 8;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  // Latched access description, held for the whole bus transaction
  logic                r_dreq_valid;
  logic [XLEN-1:0]     r_dreq_addr;
  logic                r_dreq_write;
  logic [STRB_W-1:0]   r_dreq_strobe;
  logic [XLEN-1:0]     r_dreq_wdata;
  logic [LANE_W-1:0]   r_lane;
  logic [1:0]          r_size;
  logic                r_unsigned;
  logic [RD_W-1:0]     r_rd;
  logic                r_reg_write;

  // Registered MEM/WB outputs
  logic                r_wb_valid;
  mem_wb_t             r_wb;
  logic                r_misalign;

  ex_mem_t             w_ex;
  logic [LANE_W-1:0]   w_lane;
  logic [1:0]          w_size;
  logic                w_mem_op;
  logic                w_misaligned;
  logic [STRB_W-1:0]   w_size_mask;
  logic [XLEN-1:0]     w_shifted;
  logic [XLEN-1:0]     w_load_value;
  logic                w_stall;
  logic                w_issue;
  logic                w_done;
  logic                w_wb_valid_nxt;
  mem_wb_t             w_wb_nxt;
  logic                w_misalign_nxt;

  assign w_ex     = bus.ex_mem_state;
  assign w_lane   = w_ex.alu_result[LANE_W-1:0];
  assign w_size   = w_ex.funct3[1:0];
  assign w_mem_op = bus.ex_mem_valid & (w_ex.mem_read | w_ex.mem_write);

  // Alignment check and byte-enable mask for the presented access size
  always_comb begin
    w_misaligned = 1'b0;
    w_size_mask  = STRB_W'(8'h01);
    unique case (w_size)
      2'b00: begin
        w_misaligned = 1'b0;
        w_size_mask  = STRB_W'(8'h01);
      end
      2'b01: begin
        w_misaligned = w_lane[0];
        w_size_mask  = STRB_W'(8'h03);
      end
      2'b10: begin
        w_misaligned = |w_lane[1:0];
        w_size_mask  = STRB_W'(8'h0F);
      end
      default: begin
        w_misaligned = |w_lane;
        w_size_mask  = STRB_W'(8'hFF);
      end
    endcase
  end

  // Shift the returned doubleword down to the lane and extend to XLEN
  assign w_shifted = bus.dresp_rdata >> {r_lane, 3'b000};

  always_comb begin
    w_load_value = w_shifted;
    unique case (r_size)
      2'b00: w_load_value = r_unsigned ? XLEN'(w_shifted[7:0])
                                       : {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
      2'b01: w_load_value = r_unsigned ? XLEN'(w_shifted[15:0])
                                       : {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      2'b10: w_load_value = r_unsigned ? XLEN'(w_shifted[31:0])
                                       : {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
      default: w_load_value = w_shifted;
    endcase
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, stall and next MEM/WB contents
  always_comb begin
    w_state_nxt    = r_state;
    w_stall        = 1'b0;
    w_issue        = 1'b0;
    w_done         = 1'b0;
    w_wb_valid_nxt = 1'b0;
    w_wb_nxt       = r_wb;
    w_misalign_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.ex_mem_valid) begin
          if (!w_mem_op) begin
            w_wb_valid_nxt          = 1'b1;
            w_wb_nxt.reg_dest_addr  = w_ex.reg_dest_addr;
            w_wb_nxt.reg_write      = w_ex.reg_write;
            w_wb_nxt.wb_value       = w_ex.alu_result;
          end else if (w_misaligned) begin
            w_wb_valid_nxt          = 1'b1;
            w_wb_nxt.reg_dest_addr  = w_ex.reg_dest_addr;
            w_wb_nxt.reg_write      = 1'b0;
            w_wb_nxt.wb_value       = '0;
            w_misalign_nxt          = 1'b1;
          end else begin
            w_stall     = 1'b1;
            w_issue     = 1'b1;
            w_state_nxt = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        w_stall = !bus.dresp_valid;
        if (bus.dresp_valid) begin
          w_done                 = 1'b1;
          w_wb_valid_nxt         = 1'b1;
          w_wb_nxt.reg_dest_addr = r_rd;
          w_wb_nxt.reg_write     = r_dreq_write ? 1'b0 : r_reg_write;
          w_wb_nxt.wb_value      = r_dreq_write ? '0 : w_load_value;
          w_state_nxt            = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Latch the access on issue; drop the request on completion
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_dreq_valid  <= 1'b0;
      r_dreq_addr   <= '0;
      r_dreq_write  <= 1'b0;
      r_dreq_strobe <= '0;
      r_dreq_wdata  <= '0;
      r_lane        <= '0;
      r_size        <= '0;
      r_unsigned    <= 1'b0;
      r_rd          <= '0;
      r_reg_write   <= 1'b0;
    end else if (w_issue) begin
      r_dreq_valid  <= 1'b1;
      r_dreq_addr   <= {w_ex.alu_result[XLEN-1:LANE_W], LANE_W'(0)};
      r_dreq_write  <= w_ex.mem_write;
      r_dreq_strobe <= w_ex.mem_write ? STRB_W'(w_size_mask << w_lane) : '0;
      r_dreq_wdata  <= w_ex.mem_write ? (w_ex.reg2_value << {w_lane, 3'b000}) : '0;
      r_lane        <= w_lane;
      r_size        <= w_size;
      r_unsigned    <= w_ex.funct3[2];
      r_rd          <= w_ex.reg_dest_addr;
      r_reg_write   <= w_ex.reg_write;
    end else if (w_done) begin
      r_dreq_valid  <= 1'b0;
    end
  end

  // MEM/WB and error pulse registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wb_valid <= 1'b0;
      r_wb       <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_wb_valid <= w_wb_valid_nxt;
      r_wb       <= w_wb_nxt;
      r_misalign <= w_misalign_nxt;
    end
  end

  // Stall is forced low while reset is held so upstream is released at once
  assign bus.stall        = w_stall & reset_n;
  assign bus.dreq_valid   = r_dreq_valid;
  assign bus.dreq_addr    = r_dreq_addr;
  assign bus.dreq_write   = r_dreq_write;
  assign bus.dreq_strobe  = r_dreq_strobe;
  assign bus.dreq_wdata   = r_dreq_wdata;
  assign bus.mem_wb_valid = r_wb_valid;
  assign bus.mem_wb_state = r_wb;
  assign bus.misalign_err = r_misalign;

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline MEM stage for the RV64 core. It accepts the EX/MEM bundle produced by the execute stage and performs loads and stores on the data bus through a request/response handshake. It aligns, extends and masks data, then registers the MEM/WB bundle for writeback. While a bus access is outstanding it stalls the upstream stages.

## Interface
Parameters:
- XLEN, 64, data and address width.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ex_mem_valid  in  1  ex_mem_state holds a live instruction.
- ex_mem_state  in  ex_mem  fields used:
  - alu_result: address or ALU value.
  - reg2_value: store data.
  - reg_dest_addr.
  - reg_write.
  - mem_read.
  - mem_write.
  - funct3.
- stall  out  1  upstream stages must hold ex_mem_state and ex_mem_valid.
- dreq_valid  out  1  data request outstanding.
- dreq_addr  out  XLEN  request address, aligned down to 8 bytes.
- dreq_write  out  1  1 = store, 0 = load.
- dreq_strobe  out  8  byte enables for a store; 0 for a load.
- dreq_wdata  out  XLEN  store data, lane-shifted.
- dresp_valid  in  1  single-cycle pulse completing the outstanding request.
- dresp_rdata  in  XLEN  raw 8-byte-aligned read data; valid only with dresp_valid.
- mem_wb_valid  out  1  mem_wb_state valid (registered).
- mem_wb_state  out  mem_wb  registered fields:
  - reg_dest_addr.
  - reg_write.
  - wb_value.
- misalign_err  out  1  registered, one-cycle pulse for a misaligned access.

## Operation
- The FSM has two states: IDLE and BUSY.
- "mem op" means mem_read or mem_write is 1.
- Access size by funct3[1:0]: 00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes, 11 = 8 bytes.
- lane = alu_result[2:0]. An access is misaligned when lane is not a multiple of the size.

IDLE behaviour:
- ex_mem_valid = 0: the edge writes mem_wb_valid = 0.
- Valid non-mem op: the edge writes mem_wb_valid = 1 and wb_value = alu_result, and copies reg_dest_addr and reg_write. stall = 0.
- Valid misaligned mem op:
  - No bus request is made.
  - The edge writes mem_wb_valid = 1, reg_write = 0 and misalign_err = 1.
  - stall = 0.
- Valid aligned mem op:
  - stall = 1 combinationally in this cycle.
  - The edge latches address, size, sign, store data and destination, and the FSM moves to BUSY.
  - The edge writes mem_wb_valid = 0.

BUSY behaviour:
- dreq_* are driven from the latched values and stay constant until completion.
- Store lanes: dreq_strobe = size mask << lane, and dreq_wdata = reg2_value << (8*lane).
- stall = !dresp_valid.
- On dresp_valid the edge does the following:
  - Writes mem_wb_valid = 1.
  - For a load, writes wb_value = dresp_rdata >> (8*lane), truncated to the access size.
  - Sign-extends when funct3[2] = 0 and zero-extends when funct3[2] = 1. funct3 = 111 is treated as LD.
  - For a store, writes reg_write = 0 and wb_value = 0.
  - Returns the FSM to IDLE.
- When dresp_valid = 0 the edge writes mem_wb_valid = 0.

Other rules:
- dresp_valid while in IDLE is ignored.
- misalign_err is 0 on every cycle other than the misaligned case above.

## Timing
- Reset (async assert):
  - State = IDLE; dreq_valid = 0; stall = 0.
  - mem_wb_valid = 0; mem_wb_state = all zero; misalign_err = 0.
  - Outstanding requests are abandoned, and a dresp_valid arriving after reset is ignored.
- Non-mem op or misaligned op: result appears on mem_wb one cycle after presentation.
- Mem op:
  - Cycle 0: op presented in IDLE.
  - dreq_valid is high from cycle 1.
  - With dresp_valid in cycle k ≥ 1, mem_wb_valid = 1 in cycle k+1.
  - stall is high in cycles 0..k-1 and low in cycle k; upstream advances at the end of cycle k.
- Back-to-back mem ops are seen in IDLE in cycle k+1. Minimum load-to-load spacing is 2 cycles.
- stall is combinational from state, ex_mem_valid, mem_read/mem_write, alu_result[2:0], funct3 and dresp_valid. All other outputs are registered.

## Test plan
- Non-mem op passes through:
  - Stimulus: alu_result = 0x1234, rd = 5, reg_write = 1.
  - Response: mem_wb = {5, 1, 0x1234} next cycle; stall never asserts.
- LB, sign extension, non-zero lane:
  - Stimulus: addr 0x1003, funct3 000; dresp_rdata = 0x00000000_80000000, returned 2 cycles after issue.
  - Response: dreq_addr = 0x1000; wb_value = 0xFFFFFFFF_FFFFFF80; stall high for exactly 2 cycles.
- LWU, zero extension:
  - Stimulus: addr 0x2004, funct3 110, rdata 0xDEADBEEF_00000000.
  - Response: wb_value = 0x00000000_DEADBEEF.
- SH to a lane:
  - Stimulus: addr 0x3006, reg2 = 0xABCD, funct3 001.
  - Response: dreq_write = 1; strobe = 0xC0; wdata[63:48] = 0xABCD; mem_wb reg_write = 0.
- Misaligned access:
  - Stimulus: LW at 0x4002.
  - Response: no dreq_valid; misalign_err pulses 1 cycle; reg_write = 0; stall stays 0.
- Reset while BUSY, then a stray response:
  - Stimulus: assert reset_n = 0 while BUSY; deassert; then drive dresp_valid.
  - Response: dreq_valid, stall and mem_wb_valid drop immediately; the later dresp_valid produces no mem_wb_valid.
